// File: rtl/arbiter8_pri.sv
// arbiter8_pri: eight-way fixed-priority arbiter with active-low requests
// and grants, a bounded hold time per grantee, a one-shot fairness mask
// after a timeout, and a mandatory two-cycle idle gap between grants.
module arbiter8_pri #(
  parameter int MAX_HOLD = 8
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [7:0] iReq,
  input  logic       iEI,
  output logic [7:0] oGnt,
  output logic [2:0] oGntId,
  output logic       oBusy,
  output logic       oEO
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic       busy_q, busy_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mask_valid_q, mask_valid_d;
  logic [2:0] mask_id_q, mask_id_d;

  logic [7:0] active;
  logic [7:0] others;
  logic [7:0] cand;
  logic [3:0] pick;

  // Returns {found, index} of the highest set bit; later (higher) bits overwrite.
  function automatic logic [3:0] pick_highest(input logic [7:0] act);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      if (act[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Candidate set for a new grant: drop the masked index only if someone else is asking.
  always_comb begin
    active = ~iReq;
    others = active;
    others[mask_id_q] = 1'b0;
    cand = active;
    if (mask_valid_q && (others != 8'h00)) cand = others;
    pick = pick_highest(cand);
  end

  // Next-state and registered-output logic; outputs follow the state being entered.
  always_comb begin
    state_d      = IDLE;
    gnt_d        = 8'hFF;
    gnt_id_d     = 3'd0;
    busy_d       = 1'b0;
    cnt_d        = cnt_q;
    mask_valid_d = mask_valid_q;
    mask_id_d    = mask_id_q;
    case (state_q)
      IDLE: begin
        if (!iEI && pick[3]) begin
          state_d          = GRANT;
          gnt_id_d         = pick[2:0];
          gnt_d[pick[2:0]] = 1'b0;
          busy_d           = 1'b1;
          cnt_d            = 4'd1;
          mask_valid_d     = 1'b0;
          mask_id_d        = 3'd0;
        end
      end
      GRANT: begin
        if (iReq[gnt_id_q] || iEI) begin
          state_d = GAP;
        end else if (cnt_q == MAX_HOLD_C) begin
          state_d      = GAP;
          mask_valid_d = 1'b1;
          mask_id_d    = gnt_id_q;
        end else begin
          state_d          = GRANT;
          gnt_id_d         = gnt_id_q;
          gnt_d[gnt_id_q]  = 1'b0;
          busy_d           = 1'b1;
          if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q      <= IDLE;
      gnt_q        <= 8'hFF;
      gnt_id_q     <= 3'd0;
      busy_q       <= 1'b0;
      cnt_q        <= 4'd0;
      mask_valid_q <= 1'b0;
      mask_id_q    <= 3'd0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      mask_valid_q <= mask_valid_d;
      mask_id_q    <= mask_id_d;
    end
  end

  // Cascade output depends on inputs only: low when enabled and nobody requests.
  always_comb begin
    oEO = ~(~iEI & (iReq == 8'hFF));
  end

  assign oGnt   = gnt_q;
  assign oGntId = gnt_id_q;
  assign oBusy  = busy_q;

endmodule

// File: tb/tb_arbiter8_pri.sv
// Directed testbench for arbiter8_pri with hand-computed expectations.
module tb_arbiter8_pri;

  logic       iClk;
  logic       iRst_n;
  logic [7:0] iReq;
  logic       iEI;
  logic [7:0] oGnt;
  logic [2:0] oGntId;
  logic       oBusy;
  logic       oEO;

  int n_checks = 0;
  int n_fail   = 0;

  arbiter8_pri #(.MAX_HOLD(8)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iReq   (iReq),
    .iEI    (iEI),
    .oGnt   (oGnt),
    .oGntId (oGntId),
    .oBusy  (oBusy),
    .oEO    (oEO)
  );

  // Free-running clock, period 10.
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Puts the design in IDLE with no requests pending.
  task automatic do_reset();
    iRst_n = 1'b0;
    iReq   = 8'hFF;
    iEI    = 1'b0;
    tick();
    iRst_n = 1'b1;
  endtask

  task automatic test_reset();
    iRst_n = 1'b0;
    iReq   = 8'h00;
    iEI    = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (oGnt !== 8'hFF || oBusy !== 1'b0 || oGntId !== 3'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_hold cyc%0d: gnt=%h id=%0d busy=%b, need gnt=ff id=0 busy=0", c, oGnt, oGntId, oBusy);
      end
    end
    iRst_n = 1'b1;
    tick();
    n_checks++;
    if (oGnt !== 8'h7F || oGntId !== 3'd7 || oBusy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_release: gnt=%h id=%0d busy=%b, need gnt=7f id=7 busy=1", oGnt, oGntId, oBusy);
    end
  endtask

  task automatic test_priority();
    do_reset();
    iReq = 8'b11010101;
    tick();
    n_checks++;
    if (oGnt !== 8'b11011111 || oGntId !== 3'd5 || oBusy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL priority: gnt=%b id=%0d busy=%b, need gnt=11011111 id=5 busy=1", oGnt, oGntId, oBusy);
    end
    do_reset();
    iEI  = 1'b1;
    iReq = 8'b11010101;
    tick();
    n_checks++;
    if (oGnt !== 8'hFF || oBusy !== 1'b0 || oEO !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL disabled: gnt=%h busy=%b eo=%b, need gnt=ff busy=0 eo=1", oGnt, oBusy, oEO);
    end
    iEI = 1'b0;
  endtask

  task automatic test_no_preempt();
    do_reset();
    iReq = 8'hFB;
    tick();
    n_checks++;
    if (oGntId !== 3'd2 || oGnt !== 8'hFB) begin
      n_fail++;
      $display("[TB] FAIL grant2: gnt=%h id=%0d, need gnt=fb id=2", oGnt, oGntId);
    end
    iReq = 8'h7B;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (oGntId !== 3'd2 || oGnt !== 8'hFB) begin
        n_fail++;
        $display("[TB] FAIL no_preempt cyc%0d: gnt=%h id=%0d, need gnt=fb id=2", c, oGnt, oGntId);
      end
    end
    iReq = 8'h7F;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (oGnt !== 8'hFF || oBusy !== 1'b0 || oGntId !== 3'd0) begin
        n_fail++;
        $display("[TB] FAIL release_gap cyc%0d: gnt=%h id=%0d busy=%b, need gnt=ff id=0 busy=0", c, oGnt, oGntId, oBusy);
      end
    end
    tick();
    n_checks++;
    if (oGntId !== 3'd7 || oGnt !== 8'h7F) begin
      n_fail++;
      $display("[TB] FAIL after_release: gnt=%h id=%0d, need gnt=7f id=7", oGnt, oGntId);
    end
  endtask

  // Holds a request pattern through a full timeout and checks who comes next.
  task automatic run_timeout(input logic [7:0] req, input logic [2:0] next_id, input string tag);
    do_reset();
    iReq = req;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if (oGntId !== 3'd7 || oGnt !== 8'h7F) begin
        n_fail++;
        $display("[TB] FAIL %s hold cyc%0d: gnt=%h id=%0d, need gnt=7f id=7", tag, c, oGnt, oGntId);
      end
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (oGnt !== 8'hFF || oBusy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL %s gap cyc%0d: gnt=%h busy=%b, need gnt=ff busy=0", tag, c, oGnt, oBusy);
      end
    end
    tick();
    n_checks++;
    if (oGntId !== next_id || oBusy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s next: id=%0d busy=%b, need id=%0d busy=1", tag, oGntId, oBusy, next_id);
    end
  endtask

  task automatic test_timeout();
    run_timeout(8'h3F, 3'd6, "timeout_fair");
    run_timeout(8'h7F, 3'd7, "timeout_regrant");
  endtask

  task automatic test_cascade();
    logic [7:0] pats [4] = '{8'hFF, 8'hFE, 8'h7F, 8'h00};
    logic       exp_eo [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    iEI = 1'b0;
    for (int k = 0; k < 4; k++) begin
      iReq = pats[k];
      #1;
      n_checks++;
      if (oEO !== exp_eo[k]) begin
        n_fail++;
        $display("[TB] FAIL cascade req=%h: eo=%b, need %b", pats[k], oEO, exp_eo[k]);
      end
    end
    iEI  = 1'b1;
    iReq = 8'hFF;
    iRst_n = 1'b0;
    #1;
    n_checks++;
    if (oEO !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL cascade_disabled: eo=%b, need 1", oEO);
    end
    iEI = 1'b0;
    #1;
    n_checks++;
    if (oEO !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL cascade_in_reset: eo=%b, need 0", oEO);
    end
    iRst_n = 1'b1;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    iReq = 8'h3F;
    for (int c = 0; c < 5; c++) tick();
    n_checks++;
    if (oGntId !== 3'd7 || oBusy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_grant_setup: id=%0d busy=%b, need id=7 busy=1", oGntId, oBusy);
    end
    iRst_n = 1'b0;
    tick();
    n_checks++;
    if (oGnt !== 8'hFF || oBusy !== 1'b0 || oGntId !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL mid_grant_reset: gnt=%h id=%0d busy=%b, need gnt=ff id=0 busy=0", oGnt, oGntId, oBusy);
    end
    iRst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if (oGntId !== 3'd7 || oGnt !== 8'h7F) begin
        n_fail++;
        $display("[TB] FAIL post_reset hold cyc%0d: gnt=%h id=%0d, need gnt=7f id=7", c, oGnt, oGntId);
      end
    end
    tick();
    n_checks++;
    if (oGnt !== 8'hFF || oBusy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL post_reset timeout: gnt=%h busy=%b, need gnt=ff busy=0", oGnt, oBusy);
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    iRst_n = 1'b0;
    iReq   = 8'hFF;
    iEI    = 1'b0;
    test_reset();
    test_priority();
    test_no_preempt();
    test_timeout();
    test_cascade();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arbiter8_pri.md
ARBITER8_PRI -- requirements
Module: arbiter8_pri

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, legal range 1..15: maximum consecutive cycles one requester may hold the grant.
REQ-002 SHALL have port iClk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port iRst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port iReq  input  8  active-low requests; bit 7 highest priority, bit 0 lowest.
REQ-005 SHALL have port iEI  input  1  active-low enable; 1 disables arbitration.
REQ-006 SHALL have port oGnt  output  8  registered active-low one-hot grant; all ones = no grant.
REQ-007 SHALL have port oGntId  output  3  registered binary index of current grantee; 3'b000 when no grant.
REQ-008 SHALL have port oBusy  output  1  registered, active-high; 1 exactly when oGnt is not all ones.
REQ-009 SHALL have port oEO  output  1  combinational active-low cascade output; 0 iff iEI=0 and iReq=8'hFF.

Function
REQ-010 SHALL implement states IDLE, GRANT, GAP, encoded in 2 bits; unused encoding returns to IDLE next cycle with no grant.
REQ-011 SHALL, in IDLE with iEI=0 and any iReq bit 0, select the highest-index active requester, excluding the masked index if any other request is active, and enter GRANT.
REQ-012 SHALL, in IDLE with iEI=1 or iReq=8'hFF, remain in IDLE with oGnt=8'hFF.
REQ-013 SHALL register the grant: oGnt/oGntId/oBusy update at the edge that samples the request (latency 1 cycle from request to visible grant).
REQ-014 SHALL load hold counter to 1 on entering GRANT and clear the fairness mask when a grant is issued.
REQ-015 SHALL, in GRANT, ignore all requests other than the grantee's (no preemption, even by higher priority).
REQ-016 SHALL, in GRANT, go to GAP when iReq[grantee]=1 or iEI=1; mask unchanged.
REQ-017 SHALL, in GRANT with grantee still requesting and counter = MAX_HOLD, go to GAP and set mask to grantee index (timeout).
REQ-018 SHALL otherwise, in GRANT, increment the counter and keep the grant; counter is 4 bits and never wraps.
REQ-019 SHALL, in GAP, drive oGnt=8'hFF, oGntId=0, oBusy=0 for exactly one cycle, then go to IDLE unconditionally.
REQ-020 SHALL guarantee at least two cycles with no grant between consecutive grants (GAP then IDLE).
REQ-021 SHALL re-grant a timed-out requester if it is the only active request (mask excludes only when an alternative exists).
REQ-022 SHALL never assert more than one bit of oGnt low.
REQ-023 SHALL compute oEO from inputs only, independent of state and reset.

Reset
REQ-024 SHALL, when iRst_n=0 at a rising edge, enter IDLE, set oGnt=8'hFF, oGntId=0, oBusy=0, counter=0, mask cleared (no valid index).
REQ-025 SHALL apply reset over any in-progress grant, including mid-GRANT and GAP, with no residual mask.
REQ-026 SHALL resume arbitration on the first edge with iRst_n=1.

Verification
REQ-027 Reset: iRst_n=0 two cycles with iReq=8'h00, iEI=0 -> oGnt=8'hFF, oBusy=0 throughout; first edge after release -> oGnt=8'h7F, oGntId=7.
REQ-028 Priority: iEI=0, iReq=8'b11010101 -> next cycle oGnt=8'b11011111, oGntId=5; iEI=1 instead -> no grant, oEO=1.
REQ-029 No preemption/release: grant to 2 (iReq=8'hFB), then assert bit 7 -> grant stays 2; release bit 2 -> 1 cycle GAP, 1 cycle IDLE, then oGntId=7.
REQ-030 Timeout/fairness (MAX_HOLD=8): iReq=8'h3F held -> oGntId=7 for 8 cycles, GAP, IDLE, then oGntId=6; with iReq=8'h7F only -> 7 re-granted after gap.
REQ-031 Cascade: iEI=0, iReq=8'hFF -> oEO=0; any iReq bit 0 -> oEO=1, same cycle.
REQ-032 Reset mid-grant: reset asserted during GRANT count 5 -> next edge oGnt=8'hFF, IDLE; after release highest active request granted with counter 1.
